// File: rtl/fpu_status_collector_if.sv
// rtl/fpu_status_collector_if.sv - op-completion bus from FPU execution units to the status collector
interface fpu_status_collector_if #(
  parameter int NUM_SRC = 16,
  parameter int FLAG_W  = 2,
  parameter int ADDR_W  = 4
);
  logic [ADDR_W-1:0]         addr;
  logic                      op_valid;
  logic [NUM_SRC*FLAG_W-1:0] src_flags;
  logic [NUM_SRC-1:0]        src_mask;

  modport master (output addr, op_valid, src_flags, src_mask);
  modport slave  (input  addr, op_valid, src_flags, src_mask);
endinterface

// File: rtl/fpu_status_collector.sv
// rtl/fpu_status_collector.sv - per-op FPU flag select, sticky accumulation, event counters, irq
module fpu_status_collector #(
  parameter int NUM_SRC = 16,
  parameter int FLAG_W  = 2,
  parameter int ADDR_W  = 4,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  fpu_status_collector_if.slave     op,
  input  logic                      sticky_clr,
  input  logic [FLAG_W-1:0]         irq_en,
  output logic [FLAG_W-1:0]         flag,
  output logic                      flag_valid,
  output logic [FLAG_W-1:0]         sticky,
  output logic                      irq,
  output logic [FLAG_W*CNT_W-1:0]   evt_cnt
);

  logic [FLAG_W-1:0] sel;
  logic [FLAG_W-1:0] cap;
  logic [FLAG_W-1:0] sticky_next;

  // Slot 0 is the no-op slot; out-of-range addresses never match any slot.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i != 0 && op.addr == ADDR_W'(i) && !op.src_mask[i]) begin
        sel = op.src_flags[i*FLAG_W +: FLAG_W];
      end
    end
  end

  // New flags win over a simultaneous clear.
  always_comb begin
    cap         = op.op_valid ? sel : '0;
    sticky_next = (sticky_clr ? '0 : sticky) | cap;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag       <= '0;
      flag_valid <= 1'b0;
      sticky     <= '0;
      irq        <= 1'b0;
    end else begin
      flag_valid <= op.op_valid;
      if (op.op_valid) begin
        flag <= sel;
      end
      sticky <= sticky_next;
      irq    <= |(sticky_next & irq_en);
    end
  end

  for (genvar j = 0; j < FLAG_W; j++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
      end else if (sticky_clr) begin
        cnt_q <= CNT_W'(cap[j]);
      end else if (cap[j] && cnt_q != {CNT_W{1'b1}}) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign evt_cnt[j*CNT_W +: CNT_W] = cnt_q;
  end

endmodule
